// File: rtl/arith_pkg.sv
// Shared widths and types for the arithmetic reservation station.
// The operand struct is the unit of wakeup/capture used by every entry.
package arith_pkg;

  localparam int TAG_W  = 5;
  localparam int ROB_W  = 5;
  localparam int DATA_W = 8;
  localparam int OPC_W  = 4;

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } operand_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [ROB_W-1:0] rob;
    logic [TAG_W-1:0] dest;
    logic [TAG_W-1:0] flag;
  } uop_t;

  // A waiting operand whose tag matches a valid broadcast becomes ready with that value.
  function automatic operand_t wake_operand(
    input operand_t          op,
    input logic              bcast_valid,
    input logic [TAG_W-1:0]  bcast_tag,
    input logic [DATA_W-1:0] bcast_val
  );
    operand_t res;
    res = op;
    if (bcast_valid && !op.rdy && (op.tag == bcast_tag)) begin
      res.rdy = 1'b1;
      res.val = bcast_val;
    end
    return res;
  endfunction

endpackage

// File: rtl/arith_reservation_station_if.sv
// Dispatch, result-broadcast and issue signals of the reservation station.
// The station sits on the slave modport; the surrounding core drives the master side.
interface arith_reservation_station_if;
  import arith_pkg::*;

  logic              dispatch_valid;
  logic              dispatch_ready;
  logic [OPC_W-1:0]  d_opcode;
  logic [ROB_W-1:0]  d_ROB_entry;
  logic [TAG_W-1:0]  d_dest_reg;
  logic [TAG_W-1:0]  d_flag_reg;
  logic [TAG_W-1:0]  d_a_tag;
  logic              d_a_rdy;
  logic [DATA_W-1:0] d_a_val;
  logic [TAG_W-1:0]  d_b_tag;
  logic              d_b_rdy;
  logic [DATA_W-1:0] d_b_val;
  logic [TAG_W-1:0]  d_f_tag;
  logic              d_f_rdy;
  logic [DATA_W-1:0] d_f_val;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_dest_reg;
  logic [DATA_W-1:0] cdb_val;
  logic [TAG_W-1:0]  cdb_flag_reg;
  logic [DATA_W-1:0] cdb_flags;

  logic              instr_valid;
  logic [OPC_W-1:0]  opcode;
  logic [ROB_W-1:0]  ROB_entry;
  logic [TAG_W-1:0]  dest_reg;
  logic [TAG_W-1:0]  flag_reg;
  logic [DATA_W-1:0] op_a_val;
  logic [DATA_W-1:0] op_b_val;
  logic [DATA_W-1:0] flags_val;

  modport master (
    output dispatch_valid, d_opcode, d_ROB_entry, d_dest_reg, d_flag_reg,
           d_a_tag, d_a_rdy, d_a_val, d_b_tag, d_b_rdy, d_b_val,
           d_f_tag, d_f_rdy, d_f_val,
           cdb_valid, cdb_dest_reg, cdb_val, cdb_flag_reg, cdb_flags,
    input  dispatch_ready, instr_valid, opcode, ROB_entry, dest_reg, flag_reg,
           op_a_val, op_b_val, flags_val
  );

  modport slave (
    input  dispatch_valid, d_opcode, d_ROB_entry, d_dest_reg, d_flag_reg,
           d_a_tag, d_a_rdy, d_a_val, d_b_tag, d_b_rdy, d_b_val,
           d_f_tag, d_f_rdy, d_f_val,
           cdb_valid, cdb_dest_reg, cdb_val, cdb_flag_reg, cdb_flags,
    output dispatch_ready, instr_valid, opcode, ROB_entry, dest_reg, flag_reg,
           op_a_val, op_b_val, flags_val
  );

endinterface

// File: rtl/rs_operand.sv
// One operand slot of a reservation-station entry: registers whichever source the
// top selects (hold, shifted neighbour or dispatch) after snooping the broadcast.
module rs_operand
  import arith_pkg::*;
(
  input  logic              clk,
  input  operand_t          src_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_val_i,
  output operand_t          op_o
);

  operand_t op_d;
  operand_t op_q;

  assign op_d = wake_operand(src_i, cdb_valid_i, cdb_tag_i, cdb_val_i);

  // NOTE: non-blocking assignment for state; payload has no reset because it is
  // only ever observed through the entry's valid bit, which is reset.
  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  assign op_o = op_q;

endmodule

// File: rtl/arith_reservation_station.sv
// Age-ordered, compacting issue queue for the ALU pipeline: oldest-ready select,
// removal with shift-down, and dispatch into the first free slot.
module arith_reservation_station
  import arith_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  arith_reservation_station_if.slave  rs_if
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0] count_q, count_d, count_after;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ready_vec, shift_vec;
  uop_t             uop_q [DEPTH];
  uop_t             uop_d [DEPTH];
  operand_t         a_q [DEPTH], b_q [DEPTH], f_q [DEPTH];
  operand_t         a_src [DEPTH], b_src [DEPTH], f_src [DEPTH];
  logic [IDX_W-1:0] sel;
  logic             fire;
  logic             accept;
  uop_t             d_uop;
  operand_t         d_a, d_b, d_f;

  assign d_uop = '{opcode: rs_if.d_opcode, rob: rs_if.d_ROB_entry,
                   dest: rs_if.d_dest_reg, flag: rs_if.d_flag_reg};
  assign d_a   = '{rdy: rs_if.d_a_rdy, tag: rs_if.d_a_tag, val: rs_if.d_a_val};
  assign d_b   = '{rdy: rs_if.d_b_rdy, tag: rs_if.d_b_tag, val: rs_if.d_b_val};
  assign d_f   = '{rdy: rs_if.d_f_rdy, tag: rs_if.d_f_tag, val: rs_if.d_f_val};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = valid_q[i] && a_q[i].rdy && b_q[i].rdy && f_q[i].rdy;
    end
  end

  // Priority select: scanning downward leaves the lowest (oldest) ready index.
  always_comb begin
    sel  = '0;
    fire = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel  = IDX_W'(i);
        fire = 1'b1;
      end
    end
  end

  assign rs_if.dispatch_ready = (count_q < CNT_W'(DEPTH));
  assign accept               = rs_if.dispatch_valid && rs_if.dispatch_ready;
  assign count_after          = count_q - CNT_W'(fire);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    uop_d   = uop_q;
    a_src   = a_q;
    b_src   = b_q;
    f_src   = f_q;
    for (int i = 0; i < DEPTH; i++) begin
      shift_vec[i] = fire && (IDX_W'(i) >= sel);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (shift_vec[i]) begin
        valid_d[i] = valid_q[i+1];
        uop_d[i]   = uop_q[i+1];
        a_src[i]   = a_q[i+1];
        b_src[i]   = b_q[i+1];
        f_src[i]   = f_q[i+1];
      end
    end
    if (shift_vec[DEPTH-1]) begin
      valid_d[DEPTH-1] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (CNT_W'(i) == count_after)) begin
        valid_d[i] = 1'b1;
        uop_d[i]   = d_uop;
        a_src[i]   = d_a;
        b_src[i]   = d_b;
        f_src[i]   = d_f;
      end
    end
    if (flush) begin
      valid_d = '0;
    end
    count_d = flush ? '0 : (count_after + CNT_W'(accept));
  end

  // Operand cells apply the broadcast to whatever source lands in the slot,
  // which covers held, shifted and freshly dispatched operands alike.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    rs_operand u_a (
      .clk         (clk),
      .src_i       (a_src[g]),
      .cdb_valid_i (rs_if.cdb_valid),
      .cdb_tag_i   (rs_if.cdb_dest_reg),
      .cdb_val_i   (rs_if.cdb_val),
      .op_o        (a_q[g])
    );
    rs_operand u_b (
      .clk         (clk),
      .src_i       (b_src[g]),
      .cdb_valid_i (rs_if.cdb_valid),
      .cdb_tag_i   (rs_if.cdb_dest_reg),
      .cdb_val_i   (rs_if.cdb_val),
      .op_o        (b_q[g])
    );
    rs_operand u_f (
      .clk         (clk),
      .src_i       (f_src[g]),
      .cdb_valid_i (rs_if.cdb_valid),
      .cdb_tag_i   (rs_if.cdb_flag_reg),
      .cdb_val_i   (rs_if.cdb_flags),
      .op_o        (f_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      valid_q <= '0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    uop_q <= uop_d;
  end

  always_comb begin
    rs_if.instr_valid = fire;
    rs_if.opcode      = '0;
    rs_if.ROB_entry   = '0;
    rs_if.dest_reg    = '0;
    rs_if.flag_reg    = '0;
    rs_if.op_a_val    = '0;
    rs_if.op_b_val    = '0;
    rs_if.flags_val   = '0;
    if (fire) begin
      rs_if.opcode    = uop_q[sel].opcode;
      rs_if.ROB_entry = uop_q[sel].rob;
      rs_if.dest_reg  = uop_q[sel].dest;
      rs_if.flag_reg  = uop_q[sel].flag;
      rs_if.op_a_val  = a_q[sel].val;
      rs_if.op_b_val  = b_q[sel].val;
      rs_if.flags_val = f_q[sel].val;
    end
  end

endmodule

// File: tb/tb_arith_reservation_station.sv
// Scoreboard bench: a queue-based model predicts each cycle's issue and readiness;
// a negedge monitor pops predictions whenever the station presents an issue.
module tb_arith_reservation_station;
  import arith_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  arith_reservation_station_if bus ();

  arith_reservation_station #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .rs_if (bus)
  );

  typedef struct packed {
    logic              rst;
    logic              flush;
    logic              dv;
    uop_t              u;
    operand_t          a;
    operand_t          b;
    operand_t          f;
    logic              cv;
    logic [TAG_W-1:0]  cdest;
    logic [DATA_W-1:0] cval;
    logic [TAG_W-1:0]  cflag;
    logic [DATA_W-1:0] cflags;
  } stim_t;

  typedef struct packed {
    uop_t     u;
    operand_t a;
    operand_t b;
    operand_t f;
  } ent_t;

  typedef struct {
    int                  cyc;
    uop_t                u;
    logic [3*DATA_W-1:0] vals;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   exp_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  function automatic operand_t opnd(input bit r, input int t, input int v);
    operand_t o;
    o.rdy = r;
    o.tag = TAG_W'(t);
    o.val = DATA_W'(v);
    return o;
  endfunction

  // Model's view of a broadcast: a waiting operand naming that register takes its value.
  function automatic operand_t snoop(input operand_t o, input logic v,
                                     input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    operand_t r;
    r = o;
    if (v && !o.rdy && o.tag == t) begin
      r.rdy = 1'b1;
      r.val = d;
    end
    return r;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t disp(input int opc, input int rob,
                                 input operand_t a, input operand_t b, input operand_t f);
    stim_t s;
    s = idle();
    s.dv = 1'b1;
    s.u.opcode = OPC_W'(opc);
    s.u.rob    = ROB_W'(rob);
    s.u.dest   = TAG_W'(rob + 16);
    s.u.flag   = TAG_W'(rob + 8);
    s.a = a;
    s.b = b;
    s.f = f;
    return s;
  endfunction

  function automatic stim_t with_cdb(input stim_t s_in, input int tag, input int val);
    stim_t s;
    s = s_in;
    s.cv    = 1'b1;
    s.cdest = TAG_W'(tag);
    s.cval  = DATA_W'(val);
    s.cflag = TAG_W'(31);
    return s;
  endfunction

  function automatic operand_t rand_op();
    return opnd(bit'($urandom_range(1)), $urandom_range(7), $urandom_range(255));
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.rst      = ($urandom_range(99) == 0);
    s.flush    = ($urandom_range(49) == 0);
    s.dv       = ($urandom_range(2) != 0);
    s.u.opcode = OPC_W'($urandom);
    s.u.rob    = ROB_W'($urandom);
    s.u.dest   = TAG_W'($urandom);
    s.u.flag   = TAG_W'($urandom);
    s.a        = rand_op();
    s.b        = rand_op();
    s.f        = rand_op();
    s.cv       = bit'($urandom_range(1));
    s.cdest    = TAG_W'($urandom_range(7));
    s.cval     = DATA_W'($urandom);
    s.cflag    = TAG_W'($urandom_range(7));
    s.cflags   = DATA_W'($urandom);
    return s;
  endfunction

  // Predict this cycle's outputs from the model queue, then advance it by the inputs.
  task automatic model(input stim_t s);
    int   idx;
    bit   take;
    ent_t e;
    exp_t x;
    idx = -1;
    exp_ready = (mq.size() < DEPTH);
    foreach (mq[i]) begin
      if (idx < 0 && mq[i].a.rdy && mq[i].b.rdy && mq[i].f.rdy) idx = i;
    end
    if (idx >= 0) begin
      x.cyc  = cyc;
      x.u    = mq[idx].u;
      x.vals = {mq[idx].a.val, mq[idx].b.val, mq[idx].f.val};
      exp_q.push_back(x);
    end
    if (s.rst || s.flush) begin
      mq.delete();
    end else begin
      take = s.dv && (mq.size() < DEPTH);
      if (idx >= 0) mq.delete(idx);
      foreach (mq[i]) begin
        mq[i].a = snoop(mq[i].a, s.cv, s.cdest, s.cval);
        mq[i].b = snoop(mq[i].b, s.cv, s.cdest, s.cval);
        mq[i].f = snoop(mq[i].f, s.cv, s.cflag, s.cflags);
      end
      if (take) begin
        e.u = s.u;
        e.a = snoop(s.a, s.cv, s.cdest, s.cval);
        e.b = snoop(s.b, s.cv, s.cdest, s.cval);
        e.f = snoop(s.f, s.cv, s.cflag, s.cflags);
        mq.push_back(e);
      end
    end
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    cyc++;
    mon_en = 1'b1;
    rst                = s.rst;
    flush              = s.flush;
    bus.dispatch_valid = s.dv;
    bus.d_opcode       = s.u.opcode;
    bus.d_ROB_entry    = s.u.rob;
    bus.d_dest_reg     = s.u.dest;
    bus.d_flag_reg     = s.u.flag;
    bus.d_a_rdy        = s.a.rdy;
    bus.d_a_tag        = s.a.tag;
    bus.d_a_val        = s.a.val;
    bus.d_b_rdy        = s.b.rdy;
    bus.d_b_tag        = s.b.tag;
    bus.d_b_val        = s.b.val;
    bus.d_f_rdy        = s.f.rdy;
    bus.d_f_tag        = s.f.tag;
    bus.d_f_val        = s.f.val;
    bus.cdb_valid      = s.cv;
    bus.cdb_dest_reg   = s.cdest;
    bus.cdb_val        = s.cval;
    bus.cdb_flag_reg   = s.cflag;
    bus.cdb_flags      = s.cflags;
    model(s);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) step(idle());
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      check("dispatch_ready", 32'(bus.dispatch_ready), 32'(exp_ready));
      if (bus.instr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 32'(bus.instr_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("issue_cycle", cyc, e.cyc);
          check("issue_uop", 32'({bus.opcode, bus.ROB_entry, bus.dest_reg, bus.flag_reg}),
                32'(e.u));
          check("issue_vals", 32'({bus.op_a_val, bus.op_b_val, bus.flags_val}), 32'(e.vals));
        end
      end else begin
        check("idle_fields", 32'({bus.opcode, bus.ROB_entry, bus.dest_reg, bus.flag_reg}), 32'(0));
        check("idle_vals", 32'({bus.op_a_val, bus.op_b_val, bus.flags_val}), 32'(0));
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          exp_q.delete(0);
          check("issue_valid", 32'(bus.instr_valid), 32'(1));
        end
      end
    end
  end

  initial begin
    stim_t s;
    rst   = 1'b1;
    flush = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.cdb_valid      = 1'b0;
    s = idle();
    s.rst = 1'b1;
    step(s);
    step(s);

    // Operands ready at dispatch: issue in the following cycle.
    step(disp(3, 1, opnd(1, 0, 'h10), opnd(1, 0, 'h22), opnd(1, 0, 'h00)));
    idle_n(3);

    // Operand A waits on tag 7, broadcast arrives two cycles later.
    step(disp(5, 2, opnd(0, 7, 0), opnd(1, 0, 'h01), opnd(1, 0, 'h00)));
    idle_n(1);
    step(with_cdb(idle(), 7, 'h5A));
    idle_n(3);

    // B captured from the broadcast on the dispatch edge itself.
    step(with_cdb(disp(6, 3, opnd(1, 0, 'h04), opnd(0, 3, 0), opnd(1, 0, 'h00)), 3, 'h99));
    idle_n(3);

    // Fill the queue, then wake pairs; dispatch is held off while full.
    step(disp(1, 1, opnd(0, 9, 0),  opnd(1, 0, 'h11), opnd(1, 0, 0)));
    step(disp(1, 2, opnd(0, 10, 0), opnd(1, 0, 'h12), opnd(1, 0, 0)));
    step(disp(1, 3, opnd(0, 9, 0),  opnd(1, 0, 'h13), opnd(1, 0, 0)));
    step(disp(1, 4, opnd(0, 10, 0), opnd(1, 0, 'h14), opnd(1, 0, 0)));
    step(disp(2, 5, opnd(1, 0, 'h55), opnd(1, 0, 'h15), opnd(1, 0, 0)));
    step(with_cdb(disp(2, 5, opnd(1, 0, 'h55), opnd(1, 0, 'h15), opnd(1, 0, 0)), 10, 'h44));
    step(disp(2, 5, opnd(1, 0, 'h55), opnd(1, 0, 'h15), opnd(1, 0, 0)));
    step(disp(2, 5, opnd(1, 0, 'h55), opnd(1, 0, 'h15), opnd(1, 0, 0)));
    step(with_cdb(idle(), 9, 'h33));
    idle_n(5);

    // Flush, then reset, with three pending entries and a competing dispatch/broadcast.
    for (int pass = 0; pass < 2; pass++) begin
      step(disp(7, 6, opnd(0, 12, 0), opnd(1, 0, 'h06), opnd(1, 0, 0)));
      step(disp(7, 7, opnd(0, 12, 0), opnd(1, 0, 'h07), opnd(1, 0, 0)));
      step(disp(7, 8, opnd(0, 12, 0), opnd(1, 0, 'h08), opnd(1, 0, 0)));
      s = with_cdb(disp(8, 9, opnd(1, 0, 'h09), opnd(1, 0, 'h09), opnd(1, 0, 0)), 12, 'h77);
      if (pass == 0) s.flush = 1'b1;
      else           s.rst   = 1'b1;
      step(s);
      idle_n(3);
    end

    // Random traffic, including occasional flush and reset.
    for (int k = 0; k < 1500; k++) step(rand_stim());
    idle_n(2);
    s = idle();
    s.flush = 1'b1;
    step(s);
    idle_n(2);

    @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
